ab_parallel_enforce_arbiter: RTL and testbench
==============================================

# ab_parallel_enforce_arbiter

Tick sequencer and output arbiter for two runtime enforcers (policy a, policy b) running in parallel on the same A_ctp/B_ctp plant signals. It latches each plant tick, holds it stable while both enforcers settle, and merges their edits into one final A/B pair. It then pulses each enforcer's transition stage to commit its state. It also tracks edit density and drops into a safe-output lockout when the policies intervene too often.

## Interface
Parameters:
- ENF_LAT, 1, cycles to wait for enforcer outputs to settle after raw latch (≥1)
- EDIT_LIMIT, 4, edited ticks within one window that trigger SAFE (1..2^CNT_W-1)
- WINDOW, 16, committed ticks per edit-count window (≥2)
- CNT_W, 4, width of edit_count
- SAFE_A, 0, A_ctp_final value forced in SAFE
- SAFE_B, 0, B_ctp_final value forced in SAFE

Ports:
- clk in 1 single clock, rising edge
- rst_n in 1 asynchronous active-low reset
- tick_valid in 1 one-cycle strobe: new plant sample on A_ctp/B_ctp
- A_ctp in 1 raw plant A
- B_ctp in 1 raw plant B
- raw_A_out out 1 latched A, drives both enforcers' A_ctp_in
- raw_B_out out 1 latched B, drives both enforcers' B_ctp_in
- a_A_enf in 1 policy a enforced A
- a_B_enf in 1 policy a enforced B
- b_A_enf in 1 policy b enforced A
- b_B_enf in 1 policy b enforced B
- A_ctp_final out 1 merged final A (registered)
- B_ctp_final out 1 merged final B (registered)
- final_valid out 1 one-cycle strobe: finals updated
- commit_a out 1 one-cycle strobe: advance policy a state
- commit_b out 1 one-cycle strobe: advance policy b state
- tick_drop out 1 one-cycle strobe: tick_valid arrived while busy
- safe_active out 1 high while in SAFE
- clear_safe in 1 SAFE release request (used only with AB_ARB_SAFE_LATCH_EN)
- edit_count out CNT_W edited ticks in current window

## Operation
- FSM states: IDLE, WAIT, COMMIT, SAFE.
- IDLE: tick_valid → latch A_ctp/B_ctp into raw_*_out, load wait counter to ENF_LAT, go WAIT.
- WAIT: decrement; on the edge at which the counter expires, register the merge into A/B_ctp_final and go COMMIT.
- Merge: edit_x = (a_x_enf ^ raw_x) | (b_x_enf ^ raw_x); final_x = raw_x ^ edit_x. Edits dominate pass-through.
- COMMIT: final_valid=commit_a=commit_b=1 for exactly one cycle.
  - Tick counts as edited if edit_A|edit_B.
  - edit_count increments on an edited tick, saturating at 2^CNT_W-1.
  - Window counter increments per commit. At WINDOW it wraps to 0 and edit_count clears; the wrap takes precedence over the increment in the same commit.
  - If post-update edit_count ≥ EDIT_LIMIT, go SAFE; else go IDLE.
- SAFE: safe_active=1.
  - tick_valid latches raw normally.
  - Next cycle: final_valid=1 with finals = SAFE_A/SAFE_B; commit_a/commit_b stay 0, so enforcer states freeze.
- tick_valid in WAIT or COMMIT: ignored, tick_drop=1 next cycle. Raw latches unchanged.
- Reset (any time, incl. mid-WAIT/COMMIT): state IDLE. All outputs 0, counters 0, no commit strobe emitted.

## Timing
- tick_valid sampled at edge E0. Enforcer outputs sampled at edge E0+ENF_LAT. final_valid/commit_* high during the cycle after E0+ENF_LAT.
- Minimum accepted tick spacing is ENF_LAT+2 cycles.
- raw_*_out stable from E0 until the next accepted tick.
- SAFE tick latency: final_valid high during the cycle after the sampling edge.
- All strobes are single-cycle and registered; no combinational path from inputs to outputs.

## Configuration
- AB_ARB_SAFE_LATCH_EN defined:
  - SAFE is sticky; exits to IDLE only on clear_safe sampled high.
  - Exit clears edit_count and the window counter.
  - Ticks in SAFE do not advance the window.
- AB_ARB_SAFE_LATCH_EN undefined:
  - clear_safe is ignored.
  - Each SAFE tick advances the window counter.
  - When the window wraps, SAFE exits to IDLE with edit_count=0.

## Test plan
- Defaults; A=1,B=0, both enforcers pass through → final 1/0, final_valid and commit_a/b high in the cycle after E0+1, edit_count stays 0.
- Policy a forces B=1, policy b passes → final A=1,B=1, edit_count 0→1.
- Four consecutive edited ticks (EDIT_LIMIT=4) → after 4th commit safe_active=1. Next tick gives finals 0/0, final_valid=1, commit_a/b=0.
- tick_valid reasserted one cycle after an accepted tick → tick_drop=1, raw_*_out unchanged, exactly one final_valid.
- Window wrap: 3 edited + 13 clean ticks → edit_count 0 after the 16th commit; a 17th edited tick gives 1, no SAFE.
- rst_n low during WAIT → all outputs 0 immediately, no commit strobe; with AB_ARB_SAFE_LATCH_EN in SAFE, clear_safe pulse → IDLE, edit_count=0.

Source files
------------

// File: rtl/ab_parallel_enforce_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ab_parallel_enforce_arbiter_if
// Description : Plant tick, enforcer and merged-output bundle for
//               ab_parallel_enforce_arbiter. The master side is the plant and
//               the enforcers. The slave side is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ab_parallel_enforce_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             tick_valid;
  logic             A_ctp;
  logic             B_ctp;
  logic             raw_A_out;
  logic             raw_B_out;
  logic             a_A_enf;
  logic             a_B_enf;
  logic             b_A_enf;
  logic             b_B_enf;
  logic             A_ctp_final;
  logic             B_ctp_final;
  logic             final_valid;
  logic             commit_a;
  logic             commit_b;
  logic             tick_drop;
  logic             safe_active;
  logic             clear_safe;
  logic [CNT_W-1:0] edit_count;

  modport master (
    output tick_valid, A_ctp, B_ctp, a_A_enf, a_B_enf, b_A_enf, b_B_enf,
           clear_safe,
    input  raw_A_out, raw_B_out, A_ctp_final, B_ctp_final, final_valid,
           commit_a, commit_b, tick_drop, safe_active, edit_count
  );

  modport slave (
    input  tick_valid, A_ctp, B_ctp, a_A_enf, a_B_enf, b_A_enf, b_B_enf,
           clear_safe,
    output raw_A_out, raw_B_out, A_ctp_final, B_ctp_final, final_valid,
           commit_a, commit_b, tick_drop, safe_active, edit_count
  );
endinterface
`default_nettype wire

// File: rtl/ab_parallel_enforce_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ab_parallel_enforce_arbiter
// Description : Latches plant ticks for two parallel runtime enforcers. Merges
//               their edits into one registered A/B pair and pulses both
//               commit strobes. Falls into a SAFE lockout when the edit
//               density within a window of commits reaches EDIT_LIMIT.
//               Optional macro AB_ARB_SAFE_LATCH_EN makes SAFE sticky. In that
//               mode SAFE is released only by clear_safe.
// Revision    : 1.0 - initial release
// ============================================================================
module ab_parallel_enforce_arbiter #(
  parameter int ENF_LAT    = 1,
  parameter int EDIT_LIMIT = 4,
  parameter int WINDOW     = 16,
  parameter int CNT_W      = 4,
  parameter bit SAFE_A     = 1'b0,
  parameter bit SAFE_B     = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ab_parallel_enforce_arbiter_if.slave  bus
);

  localparam int WAIT_W = (ENF_LAT < 2) ? 1 : $clog2(ENF_LAT + 1);
  localparam int WIN_W  = $clog2(WINDOW);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_SAFE   = 2'd3;

  logic [1:0]       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WIN_W-1:0] r_window;
  logic [CNT_W-1:0] r_edit_count;
  logic             r_raw_A, r_raw_B;
  logic             r_final_A, r_final_B;
  logic             r_final_valid;
  logic             r_commit;
  logic             r_tick_drop;
  logic             r_edited;

  logic             w_edit_A, w_edit_B;
  logic [CNT_W-1:0] w_count_next;
  logic             w_window_last;

  // Merge: any enforcer that disagrees with the raw value flips it
  assign w_edit_A = (bus.a_A_enf ^ r_raw_A) | (bus.b_A_enf ^ r_raw_A);
  assign w_edit_B = (bus.a_B_enf ^ r_raw_B) | (bus.b_B_enf ^ r_raw_B);

  // Saturating edit counter candidate for the commit in progress
  assign w_count_next  = (r_edited && (r_edit_count != {CNT_W{1'b1}}))
                         ? r_edit_count + 1'b1 : r_edit_count;
  assign w_window_last = (r_window == WIN_W'(WINDOW - 1));

`ifndef AB_ARB_SAFE_LATCH_EN
  // Release requests have no effect when SAFE exits on the window wrap
  logic w_unused_clear_safe;
  assign w_unused_clear_safe = bus.clear_safe;
`endif

  // Tick sequencer, merge register, window/edit tracking and SAFE lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_window      <= '0;
      r_edit_count  <= '0;
      r_raw_A       <= 1'b0;
      r_raw_B       <= 1'b0;
      r_final_A     <= 1'b0;
      r_final_B     <= 1'b0;
      r_final_valid <= 1'b0;
      r_commit      <= 1'b0;
      r_tick_drop   <= 1'b0;
      r_edited      <= 1'b0;
    end else begin
      r_final_valid <= 1'b0;
      r_commit      <= 1'b0;
      r_tick_drop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.tick_valid) begin
            r_raw_A    <= bus.A_ctp;
            r_raw_B    <= bus.B_ctp;
            r_wait_cnt <= WAIT_W'(ENF_LAT);
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_tick_drop <= bus.tick_valid;
          if (r_wait_cnt == WAIT_W'(1)) begin
            r_final_A     <= r_raw_A ^ w_edit_A;
            r_final_B     <= r_raw_B ^ w_edit_B;
            r_edited      <= w_edit_A | w_edit_B;
            r_final_valid <= 1'b1;
            r_commit      <= 1'b1;
            r_state       <= S_COMMIT;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_COMMIT: begin
          r_tick_drop <= bus.tick_valid;
          if (w_window_last) begin
            // A window wrap wins over this commit's increment
            r_window     <= '0;
            r_edit_count <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_window     <= r_window + 1'b1;
            r_edit_count <= w_count_next;
            r_state      <= (w_count_next >= CNT_W'(EDIT_LIMIT)) ? S_SAFE : S_IDLE;
          end
        end
        default: begin
          // SAFE: ticks still latch raw, but finals are forced and commits withheld
          if (bus.tick_valid) begin
            r_raw_A       <= bus.A_ctp;
            r_raw_B       <= bus.B_ctp;
            r_final_A     <= SAFE_A;
            r_final_B     <= SAFE_B;
            r_final_valid <= 1'b1;
`ifndef AB_ARB_SAFE_LATCH_EN
            if (w_window_last) begin
              r_window     <= '0;
              r_edit_count <= '0;
              r_state      <= S_IDLE;
            end else begin
              r_window <= r_window + 1'b1;
            end
`endif
          end
`ifdef AB_ARB_SAFE_LATCH_EN
          if (bus.clear_safe) begin
            r_window     <= '0;
            r_edit_count <= '0;
            r_state      <= S_IDLE;
          end
`endif
        end
      endcase
    end
  end

  assign bus.raw_A_out   = r_raw_A;
  assign bus.raw_B_out   = r_raw_B;
  assign bus.A_ctp_final = r_final_A;
  assign bus.B_ctp_final = r_final_B;
  assign bus.final_valid = r_final_valid;
  assign bus.commit_a    = r_commit;
  assign bus.commit_b    = r_commit;
  assign bus.tick_drop   = r_tick_drop;
  assign bus.safe_active = (r_state == S_SAFE);
  assign bus.edit_count  = r_edit_count;

endmodule
`default_nettype wire

// File: tb/tb_ab_parallel_enforce_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ab_parallel_enforce_arbiter
// Description : Directed self-checking bench for ab_parallel_enforce_arbiter
//               using the default parameters (ENF_LAT=1, EDIT_LIMIT=4,
//               WINDOW=16). Honours AB_ARB_SAFE_LATCH_EN for the SAFE exit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ab_parallel_enforce_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  // Enforcer models: pass raw through unless an override is armed
  logic a_A_ov = 0, a_A_val = 0, a_B_ov = 0, a_B_val = 0;
  logic b_A_ov = 0, b_A_val = 0, b_B_ov = 0, b_B_val = 0;

  ab_parallel_enforce_arbiter_if #(.CNT_W(4)) ifc ();

  ab_parallel_enforce_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.a_A_enf = a_A_ov ? a_A_val : ifc.raw_A_out;
  assign ifc.a_B_enf = a_B_ov ? a_B_val : ifc.raw_B_out;
  assign ifc.b_A_enf = b_A_ov ? b_A_val : ifc.raw_A_out;
  assign ifc.b_B_enf = b_B_ov ? b_B_val : ifc.raw_B_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one tick for exactly one rising edge, return at the negedge after it
  task automatic send_tick(input logic a, input logic b);
    @(negedge clk);
    ifc.tick_valid = 1'b1;
    ifc.A_ctp      = a;
    ifc.B_ctp      = b;
    @(negedge clk);
    ifc.tick_valid = 1'b0;
  endtask

  // Normal (non-SAFE) tick with expected finals and post-commit edit state
  task automatic tick_normal(input string tag, input logic a, input logic b,
                             input logic ea, input logic eb,
                             input logic [3:0] ecnt, input logic esafe);
    send_tick(a, b);
    chk({tag, " wait"}, {31'd0, ifc.final_valid}, 32'd0);
    @(negedge clk);
    chk({tag, " commit fv/ca/cb/A/B"},
        {27'd0, ifc.final_valid, ifc.commit_a, ifc.commit_b, ifc.A_ctp_final, ifc.B_ctp_final},
        {27'd0, 1'b1, 1'b1, 1'b1, ea, eb});
    @(negedge clk);
    chk({tag, " after fv/safe/cnt"},
        {26'd0, ifc.final_valid, ifc.safe_active, ifc.edit_count},
        {26'd0, 1'b0, esafe, ecnt});
  endtask

  function automatic logic [31:0] all_outs();
    return {18'd0, ifc.raw_A_out, ifc.raw_B_out, ifc.A_ctp_final, ifc.B_ctp_final,
            ifc.final_valid, ifc.commit_a, ifc.commit_b, ifc.tick_drop,
            ifc.safe_active, 1'b0, ifc.edit_count};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.tick_valid = 0; ifc.A_ctp = 0; ifc.B_ctp = 0; ifc.clear_safe = 0;
    repeat (2) @(negedge clk);
    chk("reset outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass-through: A=1,B=0 -> final 1/0, no edit
    tick_normal("pass", 1, 0, 1, 0, 4'd0, 0);

    // Policy a forces B=1: four consecutive edited ticks reach the limit
    a_B_ov = 1; a_B_val = 1;
    tick_normal("edit1", 1, 0, 1, 1, 4'd1, 0);
    tick_normal("edit2", 1, 0, 1, 1, 4'd2, 0);
    tick_normal("edit3", 1, 0, 1, 1, 4'd3, 0);
    tick_normal("edit4", 1, 0, 1, 1, 4'd4, 1);
    a_B_ov = 0;

    // SAFE tick: forced 0/0 finals the cycle after sampling, no commits
    send_tick(1, 1);
    chk("safe tick fv/ca/cb/A/B/rawA/rawB",
        {25'd0, ifc.final_valid, ifc.commit_a, ifc.commit_b, ifc.A_ctp_final,
         ifc.B_ctp_final, ifc.raw_A_out, ifc.raw_B_out},
        {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("safe hold", {30'd0, ifc.final_valid, ifc.safe_active}, {30'd0, 1'b0, 1'b1});

`ifdef AB_ARB_SAFE_LATCH_EN
    // Sticky SAFE: ticks do not release it, clear_safe does
    for (int i = 0; i < 12; i++) send_tick(0, 0);
    @(negedge clk);
    chk("latched safe", {31'd0, ifc.safe_active}, 32'd1);
    ifc.clear_safe = 1'b1;
    @(negedge clk);
    ifc.clear_safe = 1'b0;
    chk("clear safe/cnt", {27'd0, ifc.safe_active, ifc.edit_count}, {27'd0, 1'b0, 4'd0});
`else
    // Window stands at 6 commits; nine more SAFE ticks stay locked, the tenth wraps
    for (int i = 0; i < 9; i++) send_tick(0, 0);
    @(negedge clk);
    chk("safe before wrap", {31'd0, ifc.safe_active}, 32'd1);
    send_tick(0, 0);
    @(negedge clk);
    chk("safe wrap exit", {27'd0, ifc.safe_active, ifc.edit_count}, {27'd0, 1'b0, 4'd0});
`endif

    // Tick reasserted during WAIT: dropped, raw unchanged, one final_valid
    @(negedge clk);
    ifc.tick_valid = 1; ifc.A_ctp = 0; ifc.B_ctp = 1;
    @(negedge clk);
    ifc.A_ctp = 1; ifc.B_ctp = 0;
    @(negedge clk);
    ifc.tick_valid = 0;
    chk("drop fv/drop/rawA/rawB/A/B",
        {26'd0, ifc.final_valid, ifc.tick_drop, ifc.raw_A_out, ifc.raw_B_out,
         ifc.A_ctp_final, ifc.B_ctp_final},
        {26'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("drop next", {30'd0, ifc.final_valid, ifc.tick_drop}, 32'd0);
    @(negedge clk);
    chk("drop single fv", {31'd0, ifc.final_valid}, 32'd0);

    // Fresh window for the wrap test
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Policy b forces A=0: three edited ticks
    b_A_ov = 1; b_A_val = 0;
    for (int i = 1; i <= 3; i++) tick_normal($sformatf("wrap_e%0d", i), 1, 0, 0, 0, 4'(i), 0);
    b_A_ov = 0;
    for (int i = 4; i <= 15; i++) tick_normal($sformatf("wrap_c%0d", i), 0, 1, 0, 1, 4'd3, 0);
    tick_normal("wrap_c16", 0, 1, 0, 1, 4'd0, 0);

    // 17th tick: both policies edit different bits
    a_A_ov = 1; a_A_val = 0; b_B_ov = 1; b_B_val = 1;
    tick_normal("wrap_e17", 1, 0, 0, 1, 4'd1, 0);
    a_A_ov = 0; b_B_ov = 0;

    // Reset asserted mid-WAIT: everything clears at once, no commit follows
    send_tick(1, 1);
    chk("pre-reset raw", {30'd0, ifc.raw_A_out, ifc.raw_B_out}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("reset mid-wait", all_outs(), 32'd0);
    @(negedge clk);
    chk("reset no commit1", {29'd0, ifc.final_valid, ifc.commit_a, ifc.commit_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset no commit2", all_outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
